servo_req_sched: RTL and testbench
==================================

Name: servo_req_sched

Overview:
- Shares one servo PWM channel between NUM_REQ requesters, e.g. UI input, autonomous sequencer and debug UART.
- Arbitrates position requests round-robin and drives the shared position bus and servo enable.
- Holds enable high for a fixed time, then a guard gap, before the next grant.
- Sits between the requesters and the PWM generator; replaces change-detect enable gating with explicit, scheduled enable windows.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- N, 8, position word width.
- HOLD_CYCLES, 10, enable-high duration per accepted request in clk cycles (>=1).
- GAP_CYCLES, 2, enable-low guard after each hold before the next grant (>=0).

Ports:
- clk  input  1  system clock (10 MHz).
- reset  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_data  input  NUM_REQ*N  packed positions; requester i at bits [i*N +: N].
- req_ready  output  NUM_REQ  one-hot one-cycle accept pulse.
- pos_out  output  N  position to PWM generator.
- servo_en  output  1  PWM enable.
- grant_id  output  $clog2(NUM_REQ)  index of the last accepted requester.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- One clock, synchronous active-high reset.
- All outputs are registered.
- Reset values: pos_out=0, servo_en=0, req_ready=0, grant_id=0, busy=0, rr_ptr=0, counter=0, state=IDLE.
- Transfer rule: a transfer occurs on the edge where req_valid[i] && req_ready[i]. A requester must hold req_valid and req_data stable until it sees req_ready.
- IDLE:
  - If any req_valid is high, select g = first index at or after rr_ptr with req_valid set, searching with wrap-around.
  - Go to GRANT and drive req_ready[g]=1 during the GRANT cycle.
- GRANT (exactly 1 cycle):
  - If req_valid[g] is still high: transfer. Capture pos_out<=req_data[g], set grant_id<=g, rr_ptr<=(g+1) mod NUM_REQ, counter<=0, servo_en<=1, go to HOLD.
  - If req_valid[g] has dropped (withdrawn): no transfer. pos_out, rr_ptr and grant_id are unchanged. Return to IDLE.
- HOLD:
  - servo_en=1 for exactly HOLD_CYCLES consecutive cycles, beginning the cycle pos_out takes the new value.
  - On the last hold cycle, go to GAP, or to IDLE when GAP_CYCLES=0.
- GAP: servo_en=0 for exactly GAP_CYCLES cycles, then IDLE.
- Latency: req_valid sampled high in IDLE -> req_ready high next cycle -> pos_out/servo_en update one cycle later.
- Minimum request spacing: 2 + HOLD_CYCLES + GAP_CYCLES cycles.
- Requests arriving while busy are held pending. They are not dropped and not ready'ed until the next IDLE arbitration.
- req_ready is never asserted outside GRANT and never multi-hot.
- Counter width is $clog2(max(HOLD_CYCLES,GAP_CYCLES)+1). The counter saturates, never wraps.
- Reset asserted mid-operation (any state): next cycle all outputs take their reset values; any in-flight grant is abandoned.
- rr_ptr wrap: after a grant to NUM_REQ-1, the search starts at 0.

Optional Feature:
- Macro SERVO_SKIP_SAME_EN.
- Defined: in GRANT, if the transfer occurs and req_data[g]==pos_out, the transfer still completes (req_ready pulse, rr_ptr and grant_id updated). The block skips HOLD and GAP, servo_en stays 0, and it returns directly to IDLE.
- Undefined: identical values are scheduled normally with the full HOLD and GAP.

Test Plan:
All scenarios use NUM_REQ=4, N=8, HOLD_CYCLES=10, GAP_CYCLES=2 unless stated.
1. After reset, req_valid=4'b0010 with data 0x80 -> req_ready=4'b0010 for 1 cycle; pos_out=0x80, grant_id=1; servo_en high exactly 10 cycles; busy low 13 cycles after the ready pulse.
2. All four valid simultaneously (data 0x10/0x20/0x30/0x40), held -> grants in order 0,1,2,3, each 14 cycles apart. Then with valid on 0 and 2 -> order 0,2.
3. Withdraw: req_valid[2] high one cycle then low in the GRANT cycle -> no transfer; pos_out and grant_id unchanged, servo_en stays 0, next valid requester is served normally.
4. Reset asserted on the 5th HOLD cycle -> next cycle servo_en=0, pos_out=0, busy=0, req_ready=0. A subsequent request from 3 is granted before 0, since rr_ptr reset to 0 and only 3 is valid.
5. Request 0x55 twice from requester 0 -> with SERVO_SKIP_SAME_EN the second request gets req_ready but servo_en stays 0. Without the macro, the second request gets a 10-cycle enable.
6. GAP_CYCLES=0 build, two requesters continuously valid -> servo_en low for exactly 2 cycles between 10-cycle windows (IDLE + GRANT).

Source files
------------

// File: rtl/servo_req_sched.sv
// rtl/servo_req_sched.sv - round-robin scheduler sharing one servo PWM channel with timed enable windows
// Optional: define SERVO_SKIP_SAME_EN to skip the enable window when the granted position equals pos_out.
module servo_req_sched #(
   parameter int NUM_REQ     = 4,
   parameter int N           = 8,
   parameter int HOLD_CYCLES = 10,
   parameter int GAP_CYCLES  = 2,
   localparam int IW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [NUM_REQ*N-1:0] req_data,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic [N-1:0]         pos_out,
   output logic                 servo_en,
   output logic [IW-1:0]        grant_id,
   output logic                 busy
);

   localparam int MAXC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);

   localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LAST  = (GAP_CYCLES > 0) ? CW'(GAP_CYCLES - 1) : '0;
   localparam logic [CW-1:0] CNT_MAX   = CW'(MAXC);
   localparam logic [IW-1:0] LAST_REQ  = IW'(NUM_REQ - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_GRANT = 2'd1;
   localparam logic [1:0] S_HOLD  = 2'd2;
   localparam logic [1:0] S_GAP   = 2'd3;

   logic [1:0]    state;
   logic [IW-1:0] rr_ptr;
   logic [IW-1:0] sel;
   logic [CW-1:0] counter;

   logic [IW-1:0]      pick;
   logic               pick_found;
   logic [NUM_REQ-1:0] pick_oh;
   logic [N-1:0]       sel_data;
   logic [IW-1:0]      rr_next;
   logic [CW-1:0]      counter_inc;
   logic               skip_same;

   // First valid requester at or after rr_ptr, wrapping around.
   always_comb begin
      int idx;
      idx        = 0;
      pick       = rr_ptr;
      pick_found = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = (int'(rr_ptr) + k) % NUM_REQ;
         if (!pick_found && req_valid[idx]) begin
            pick       = IW'(idx);
            pick_found = 1'b1;
         end
      end
   end

   assign pick_oh     = NUM_REQ'(1) << pick;
   assign sel_data    = req_data[int'(sel)*N +: N];
   assign rr_next     = (sel == LAST_REQ) ? '0 : sel + 1'b1;
   assign counter_inc = (counter == CNT_MAX) ? counter : counter + 1'b1;

`ifdef SERVO_SKIP_SAME_EN
   assign skip_same = (sel_data == pos_out);
`else
   assign skip_same = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         rr_ptr    <= '0;
         sel       <= '0;
         counter   <= '0;
         req_ready <= '0;
         pos_out   <= '0;
         servo_en  <= 1'b0;
         grant_id  <= '0;
         busy      <= 1'b0;
      end else begin
         req_ready <= '0;
         case (state)
            S_IDLE: begin
               if (pick_found) begin
                  sel       <= pick;
                  req_ready <= pick_oh;
                  state     <= S_GRANT;
                  busy      <= 1'b1;
               end
            end
            S_GRANT: begin
               if (req_valid[sel]) begin
                  grant_id <= sel;
                  rr_ptr   <= rr_next;
                  if (skip_same) begin
                     state <= S_IDLE;
                     busy  <= 1'b0;
                  end else begin
                     pos_out  <= sel_data;
                     servo_en <= 1'b1;
                     counter  <= '0;
                     state    <= S_HOLD;
                  end
               end else begin
                  // Requester withdrew before the accept edge: nothing changes.
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end
            end
            S_HOLD: begin
               if (counter == HOLD_LAST) begin
                  servo_en <= 1'b0;
                  counter  <= '0;
                  if (GAP_CYCLES == 0) begin
                     state <= S_IDLE;
                     busy  <= 1'b0;
                  end else begin
                     state <= S_GAP;
                  end
               end else begin
                  counter <= counter_inc;
               end
            end
            S_GAP: begin
               if (counter == GAP_LAST) begin
                  counter <= '0;
                  state   <= S_IDLE;
                  busy    <= 1'b0;
               end else begin
                  counter <= counter_inc;
               end
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_servo_req_sched.sv
// tb/tb_servo_req_sched.sv - scoreboard bench for servo_req_sched (default config plus a GAP_CYCLES=0 instance)
module tb_servo_req_sched;

   typedef struct {
      logic [3:0] ready;
      logic [7:0] pos;
      logic [1:0] gid;
      int         len;
      int         gap;
      int         off;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  req_valid = '0;
   logic [31:0] req_data = '0;
   logic [3:0]  req_ready;
   logic [7:0]  pos_out;
   logic        servo_en;
   logic [1:0]  grant_id;
   logic        busy;

   logic [3:0]  v2 = '0;
   logic [31:0] d2 = 32'h2211_0000;
   logic [3:0]  ready2;
   logic [7:0]  pos2;
   logic        en2;
   logic [1:0]  gid2;
   logic        busy2;

   int   total = 0;
   int   bad = 0;
   exp_t sb[$];

   always #50 clk = ~clk;

   servo_req_sched #(.NUM_REQ(4), .N(8), .HOLD_CYCLES(10), .GAP_CYCLES(2)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .pos_out(pos_out), .servo_en(servo_en),
      .grant_id(grant_id), .busy(busy)
   );

   servo_req_sched #(.NUM_REQ(4), .N(8), .HOLD_CYCLES(10), .GAP_CYCLES(0)) dut_g0 (
      .clk(clk), .reset(reset), .req_valid(v2), .req_data(d2),
      .req_ready(ready2), .pos_out(pos2), .servo_en(en2),
      .grant_id(gid2), .busy(busy2)
   );

   task automatic check(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   // Requester model: drop valid right after the accept edge.
   initial begin
      logic [3:0] acc;
      forever begin
         @(negedge clk);
         acc = req_ready & req_valid;
         @(posedge clk);
         #1;
         req_valid = req_valid & ~acc;
      end
   end

   // Monitor: pops one expectation per ready pulse and tracks its response.
   initial begin
      exp_t cur;
      int   cyc = 0, r_cyc = 0, last_r = 0, run = 0;
      bit   act = 0, run_done = 1;
      forever begin
         @(negedge clk);
         cyc++;
         if (req_ready != 0) begin
            if (sb.size() == 0) begin
               check("unexpected_ready", int'(req_ready), 0);
            end else begin
               cur = sb.pop_front();
               check("ready_vec", int'(req_ready), int'(cur.ready));
               if (cur.gap != 0) check("ready_spacing", cyc - last_r, cur.gap);
               last_r   = cyc;
               r_cyc    = cyc;
               act      = 1;
               run      = 0;
               run_done = (cur.len == 0);
            end
         end
         if (act) begin
            if (cyc == r_cyc + 1) begin
               check("pos_out", int'(pos_out), int'(cur.pos));
               check("grant_id", int'(grant_id), int'(cur.gid));
               check("en_start", int'(servo_en), int'(cur.len > 0));
            end
            if (!run_done && cyc > r_cyc) begin
               if (servo_en) run++;
               else begin
                  check("en_len", run, cur.len);
                  run_done = 1;
               end
            end
            if (cyc == r_cyc + cur.off - 1) check("busy_before_idle", int'(busy), 1);
            if (cyc == r_cyc + cur.off) check("busy_idle", int'(busy), 0);
            if (cyc > r_cyc + cur.off && run_done) act = 0;
         end
      end
   end

   task automatic push(input logic [3:0] r, input logic [7:0] p, input logic [1:0] g,
                       input int len, input int gap, input int off);
      exp_t e;
      e.ready = r; e.pos = p; e.gid = g; e.len = len; e.gap = gap; e.off = off;
      sb.push_back(e);
   endtask

   task automatic request(input int i, input logic [7:0] d);
      req_data[i*8 +: 8] = d;
      req_valid[i] = 1'b1;
   endtask

   task automatic wait_ready(input int i);
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (req_ready[i]) return;
      end
      check("ready_timeout", 0, 1);
   endtask

   task automatic wait_done();
      int c;
      c = 0;
      while (req_valid != 0 && c < 300) begin
         @(posedge clk);
         c++;
      end
      if (c >= 300) check("drain_timeout", int'(req_valid), 0);
      repeat (16) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      bit prev;
      int run, nhi;
      do_reset();
      @(negedge clk);
      check("rst_pos", int'(pos_out), 0);
      check("rst_en", int'(servo_en), 0);
      check("rst_ready", int'(req_ready), 0);
      check("rst_gid", int'(grant_id), 0);
      check("rst_busy", int'(busy), 0);
      @(posedge clk);
      #1;

      // Single request from requester 1
      push(4'b0010, 8'h80, 2'd1, 10, 0, 13);
      request(1, 8'h80);
      wait_done();

      // All four held together, then 0 and 2
      do_reset();
      push(4'b0001, 8'h10, 2'd0, 10, 0, 13);
      push(4'b0010, 8'h20, 2'd1, 10, 14, 13);
      push(4'b0100, 8'h30, 2'd2, 10, 14, 13);
      push(4'b1000, 8'h40, 2'd3, 10, 14, 13);
      req_data = 32'h4030_2010;
      req_valid = 4'b1111;
      wait_done();
      push(4'b0001, 8'h11, 2'd0, 10, 0, 13);
      push(4'b0100, 8'h33, 2'd2, 10, 14, 13);
      req_data[7:0] = 8'h11;
      req_data[23:16] = 8'h33;
      req_valid = 4'b0101;
      wait_done();

      // Withdraw in the GRANT cycle, then requester 3 served normally
      push(4'b0100, 8'h33, 2'd2, 0, 0, 1);
      request(2, 8'hee);
      @(posedge clk);
      #1;
      req_valid[2] = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      push(4'b1000, 8'h99, 2'd3, 10, 0, 13);
      request(3, 8'h99);
      wait_done();

      // Reset on the 5th HOLD cycle
      push(4'b0010, 8'h77, 2'd1, 5, 0, 6);
      request(1, 8'h77);
      wait_ready(1);
      repeat (5) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check("midrst_en", int'(servo_en), 0);
      check("midrst_pos", int'(pos_out), 0);
      check("midrst_busy", int'(busy), 0);
      check("midrst_ready", int'(req_ready), 0);
      @(posedge clk);
      #1;
      push(4'b1000, 8'hc3, 2'd3, 10, 0, 13);
      push(4'b0001, 8'h0a, 2'd0, 10, 14, 13);
      request(3, 8'hc3);
      wait_ready(3);
      @(posedge clk);
      #1;
      request(0, 8'h0a);
      wait_done();

      // Same position twice from requester 0
      push(4'b0001, 8'h55, 2'd0, 10, 0, 13);
      request(0, 8'h55);
      wait_done();
`ifdef SERVO_SKIP_SAME_EN
      push(4'b0001, 8'h55, 2'd0, 0, 0, 1);
`else
      push(4'b0001, 8'h55, 2'd0, 10, 0, 13);
`endif
      request(0, 8'h55);
      wait_done();

      // GAP_CYCLES=0 instance: 10-high / 2-low enable pattern under continuous load
      v2 = 4'b0011;
      prev = 1'b0;
      run = 0;
      nhi = 0;
      for (int c = 0; c < 70; c++) begin
         @(negedge clk);
         if (en2 == prev) run++;
         else begin
            if (prev) begin
               check("g0_en_high", run, 10);
               nhi++;
            end else if (nhi > 0) begin
               check("g0_en_low", run, 2);
            end
            prev = en2;
            run = 1;
         end
      end
      v2 = '0;
      check("g0_windows_seen", int'(nhi >= 4), 1);

      repeat (5) @(posedge clk);
      check("scoreboard_empty", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #20ms;
      $display("FAIL global_timeout: got 1 expected 0");
      $fatal(1, "timeout");
   end

endmodule
